// File: rtl/vga_char_ctrl.sv
// Character buffer controller for a VGA text renderer.
// Ports: clk, reset (async, active-high); cmd_valid/cmd_op/cmd_data
//   in; cmd_ready out; char_data[256] buffer, cursor, wrapped out.
module vga_char_ctrl #(
  parameter int         COLS      = 16,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic [7:0] char_data [256],
  output logic [7:0] cursor,
  output logic       wrapped
);

  typedef enum logic {IDLE, CLEARING} state_e;

  localparam logic [1:0] OP_PUT  = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_NL   = 2'b11;

  // COLS == 256 folds to step 0 / mask 0, so NEWLINE lands on 0.
  localparam logic [7:0] STEP = 8'(COLS % 256);
  localparam logic [7:0] MASK = 8'((256 - COLS) % 256);

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] cur_q, cur_d;
  logic       wrap_q, wrap_d;
  logic [7:0] mem_q [256];

  logic       accept;
  logic       we;
  logic [7:0] wa, wd;
  logic [7:0] nl;

  assign accept = cmd_valid && cmd_ready;
  assign nl     = (cur_q & MASK) + STEP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept && cmd_op == OP_CLR)
          state_d = CLEARING;
      CLEARING:
        if (idx_q == 8'hFF)
          state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
  end

  always_comb begin
    we     = 1'b0;
    wa     = cur_q;
    wd     = cmd_data;
    idx_d  = idx_q;
    cur_d  = cur_q;
    wrap_d = 1'b0;
    if (state_q == CLEARING) begin
      we    = 1'b1;
      wa    = idx_q;
      wd    = FILL_CHAR;
      idx_d = idx_q + 8'd1;
      if (idx_q == 8'hFF)
        cur_d = 8'd0;
    end else if (accept) begin
      unique case (cmd_op)
        OP_PUT: begin
          we     = 1'b1;
          cur_d  = cur_q + 8'd1;
          wrap_d = (cur_q == 8'hFF);
        end
        OP_SET: cur_d = cmd_data;
        OP_CLR: idx_d = 8'd0;
        OP_NL: begin
          cur_d  = nl;
          wrap_d = (nl < cur_q);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= 8'd0;
      cur_q  <= 8'd0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cur_q  <= cur_d;
      wrap_q <= wrap_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++)
        mem_q[i] <= FILL_CHAR;
    end else if (we) begin
      mem_q[wa] <= wd;
    end
  end

  assign char_data = mem_q;
  assign cursor    = cur_q;
  assign wrapped   = wrap_q;

endmodule

// File: tb/tb_vga_char_ctrl.sv
// Directed testbench for vga_char_ctrl with a behavioural buffer model.
// Model state is compared against the DUT every cycle after reset.
module tb_vga_char_ctrl;

  localparam int         COLS = 16;
  localparam logic [7:0] FILL = 8'h20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic [7:0] char_data [256];
  logic [7:0] cursor;
  logic       wrapped;

  int vectors = 0;
  int miscompares = 0;
  bit run_cmp = 1'b0;

  logic [7:0] m_mem [256];
  int         m_cur;
  bit         m_wrap;
  int         m_left;

  vga_char_ctrl #(.COLS(COLS), .FILL_CHAR(FILL)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .char_data (char_data),
    .cursor    (cursor),
    .wrapped   (wrapped)
  );

  always #5 clk = ~clk;

  // Model: m_left counts clear writes still to do (0 = idle).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) m_mem[i] = FILL;
      m_cur  = 0;
      m_wrap = 0;
      m_left = 0;
    end else begin
      m_wrap = 0;
      if (m_left > 0) begin
        m_mem[256 - m_left] = FILL;
        m_left = m_left - 1;
        if (m_left == 0) m_cur = 0;
      end else if (cmd_valid) begin
        int n;
        case (cmd_op)
          2'b00: begin
            m_mem[m_cur] = cmd_data;
            n = (m_cur + 1) % 256;
            m_wrap = (n < m_cur);
            m_cur = n;
          end
          2'b01: m_cur = int'(cmd_data);
          2'b10: m_left = 256;
          default: begin
            n = ((m_cur / COLS) * COLS + COLS) % 256;
            m_wrap = (n < m_cur);
            m_cur = n;
          end
        endcase
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (run_cmp) begin
      int bad;
      chk("cyc_ready", 32'(cmd_ready), 32'(m_left == 0));
      chk("cyc_cursor", 32'(cursor), 32'(m_cur));
      chk("cyc_wrapped", 32'(wrapped), 32'(m_wrap));
      bad = -1;
      for (int i = 0; i < 256; i++)
        if (char_data[i] !== m_mem[i] && bad < 0) bad = i;
      vectors++;
      if (bad >= 0) begin
        miscompares++;
        $display("FAIL cyc_buf[%0d] got=%h exp=%h at %0t",
                 bad, char_data[bad], m_mem[bad], $time);
      end
    end
  end

  task automatic all_fill(string name);
    int bad_d, bad_m;
    bad_d = -1;
    bad_m = -1;
    for (int i = 0; i < 256; i++) begin
      if (char_data[i] !== FILL && bad_d < 0) bad_d = i;
      if (m_mem[i] !== FILL && bad_m < 0) bad_m = i;
    end
    vectors++;
    if (bad_d >= 0 || bad_m >= 0) begin
      miscompares++;
      $display("FAIL %s dut_first_bad=%0d model_first_bad=%0d exp all %h",
               name, bad_d, bad_m, FILL);
    end
  endtask

  task automatic send(logic [1:0] op, logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [7:0] d;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run_cmp = 1'b1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cursor", 32'(cursor), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    all_fill("rst_buf");

    send(2'b00, 8'h41);
    send(2'b00, 8'h42);
    chk("put_e0", 32'(char_data[0]), 32'h41);
    chk("put_e1", 32'(char_data[1]), 32'h42);
    chk("put_cur", 32'(cursor), 32'd2);
    chk("put_mcur", 32'(m_cur), 32'd2);
    chk("put_ready", 32'(cmd_ready), 32'd1);

    send(2'b01, 8'hFF);
    chk("set_nowrap", 32'(wrapped), 32'd0);
    send(2'b00, 8'h5A);
    chk("wrap_e255", 32'(char_data[255]), 32'h5A);
    chk("wrap_cur", 32'(cursor), 32'd0);
    chk("wrap_pulse", 32'(wrapped), 32'd1);
    chk("wrap_mpulse", 32'(m_wrap), 32'd1);
    @(negedge clk);
    chk("wrap_end", 32'(wrapped), 32'd0);

    send(2'b01, 8'h13);
    send(2'b11, 8'h00);
    chk("nl_cur", 32'(cursor), 32'h20);
    chk("nl_mcur", 32'(m_cur), 32'h20);
    chk("nl_nowrap", 32'(wrapped), 32'd0);
    send(2'b01, 8'h40);
    send(2'b11, 8'hFF);
    chk("nl_edge", 32'(cursor), 32'h50);
    send(2'b01, 8'hF5);
    send(2'b11, 8'h00);
    chk("nlw_cur", 32'(cursor), 32'd0);
    chk("nlw_pulse", 32'(wrapped), 32'd1);
    @(negedge clk);
    chk("nlw_end", 32'(wrapped), 32'd0);

    send(2'b01, 8'h00);
    for (int i = 0; i < 256; i++) begin
      d = 8'(i) | 8'h80;
      send(2'b00, d);
    end
    chk("fill_e7", 32'(char_data[7]), 32'h87);
    send(2'b01, 8'h77);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    @(negedge clk);
    cmd_op   = 2'b00;
    cmd_data = 8'h99;
    cnt = 0;
    while (!cmd_ready && cnt < 400) begin
      chk("clr_cur_hold", 32'(cursor), 32'h77);
      cnt++;
      @(negedge clk);
    end
    chk("clr_busy_cycles", 32'(cnt), 32'd256);
    chk("clr_cur0", 32'(cursor), 32'd0);
    all_fill("clr_buf");
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("held_put_e0", 32'(char_data[0]), 32'h99);
    chk("held_put_cur", 32'(cursor), 32'd1);

    send(2'b00, 8'h33);
    send(2'b01, 8'h30);
    send(2'b10, 8'h00);
    repeat (99) @(negedge clk);
    chk("abort_busy", 32'(cmd_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_cur", 32'(cursor), 32'd0);
    all_fill("abort_buf");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    all_fill("abort_quiet");
    send(2'b00, 8'h61);
    chk("post_rst_e0", 32'(char_data[0]), 32'h61);
    chk("post_rst_cur", 32'(cursor), 32'd1);

    for (int i = 0; i < 50; i++) begin
      cmd_op   = 2'($urandom_range(3));
      cmd_data = 8'($urandom_range(255));
      @(negedge clk);
    end
    chk("idle_cur", 32'(cursor), 32'd1);
    chk("idle_e0", 32'(char_data[0]), 32'h61);
    chk("idle_e1", 32'(char_data[1]), 32'(FILL));

    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_char_ctrl.md
VGA_CHAR_CTRL -- requirements
Module: vga_char_ctrl

Interface
REQ-001 Parameter COLS, default 16, meaning characters per text row; the block SHALL support only powers of two that divide 256.
REQ-002 Parameter FILL_CHAR, default 8'h20, meaning code written by reset and by CLEAR.
REQ-003 Port clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port cmd_valid  input  1  requester presents a command.
REQ-006 Port cmd_op  input  2  opcode: 00 PUT, 01 SETCUR, 10 CLEAR, 11 NEWLINE.
REQ-007 Port cmd_data  input  8  character code for PUT; cursor address for SETCUR; ignored otherwise.
REQ-008 Port cmd_ready  output  1  block can accept a command this cycle.
REQ-009 Port char_data  output  8 x 256 (unpacked [7:0] [255:0])  character buffer driven to the VGA text renderer.
REQ-010 Port cursor  output  8  current write address.
REQ-011 Port wrapped  output  1  one-cycle pulse when the cursor wraps past 255.

Function
REQ-012 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; the block SHALL ignore cmd_op and cmd_data at all other edges.
REQ-013 States SHALL be IDLE and CLEARING; cmd_ready SHALL equal (state == IDLE), combinationally.
REQ-014 PUT SHALL write cmd_data to char_data[cursor] and set cursor to cursor+1 modulo 256 on the accepting edge.
REQ-015 SETCUR SHALL set cursor to cmd_data on the accepting edge, leaving char_data unchanged.
REQ-016 NEWLINE SHALL set cursor to (cursor rounded down to a multiple of COLS) + COLS, modulo 256, leaving char_data unchanged.
REQ-017 PUT, SETCUR and NEWLINE SHALL complete in one cycle with the state remaining IDLE, allowing back-to-back acceptance every cycle.
REQ-018 wrapped SHALL be 1 for exactly the cycle after an edge where PUT or NEWLINE moves cursor from a value in 240..255 to a lower value; SETCUR SHALL never assert wrapped.
REQ-019 CLEAR SHALL move IDLE->CLEARING and load an 8-bit index counter with 0 on the accepting edge.
REQ-020 In CLEARING, each edge SHALL write FILL_CHAR to char_data[index] and increment index.
REQ-021 The edge that writes index 255 SHALL set state to IDLE and cursor to 0; cmd_ready SHALL therefore be 0 for exactly 256 cycles following acceptance of CLEAR.
REQ-022 The cursor SHALL hold its pre-CLEAR value during CLEARING, and wrapped SHALL stay 0.
REQ-023 Entries not addressed by a write in a given cycle SHALL hold their value; at most one entry SHALL change per cycle.
REQ-024 The block SHALL perform no arithmetic wider than 8 bits; all cursor and index overflow SHALL wrap silently.

Reset
REQ-025 While reset is 1, asynchronously and regardless of clk: every char_data entry = FILL_CHAR, cursor = 0, state = IDLE, index = 0, wrapped = 0, and therefore cmd_ready = 1.
REQ-026 Reset asserted during CLEARING SHALL abort the sequence immediately; after release the block SHALL be in IDLE with the full buffer equal to FILL_CHAR.
REQ-027 After reset deassertion, the first rising edge SHALL be able to accept a command.

Verification
REQ-028 Reset, then PUT 8'h41, PUT 8'h42 back-to-back -> char_data[0]=8'h41, char_data[1]=8'h42, cursor=2, cmd_ready stays 1.
REQ-029 SETCUR 8'hFF, then PUT 8'h5A -> char_data[255]=8'h5A, cursor=0, wrapped=1 for one cycle only.
REQ-030 SETCUR 8'h13, NEWLINE -> cursor=8'h20; SETCUR 8'hF5, NEWLINE -> cursor=0, wrapped pulses once.
REQ-031 Fill the buffer with non-FILL values, SETCUR 8'h77, then CLEAR with cmd_valid held high carrying PUT -> cmd_ready=0 for exactly 256 cycles, cursor=8'h77 throughout, then all entries=8'h20 and cursor=0; the held PUT is accepted on the first cycle that cmd_ready=1 and writes entry 0.
REQ-032 Assert reset for one cycle 100 cycles into CLEAR -> all entries=8'h20, cursor=0, cmd_ready=1 immediately, with no further index writes.
REQ-033 Drive cmd_valid=0 with toggling cmd_op and cmd_data for 50 cycles -> no change to char_data, cursor or wrapped.
